// File: rtl/tx_packet_queue.sv
// Transmit packet queue: buffers {dest_id, data, src_id} packets and presents them one at a time under a valid/ready grant.
// Optional grant-wait timeout with packet discard is enabled by defining TX_TIMEOUT_EN.
module tx_packet_queue #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ID_WIDTH-1:0]              dest_id,
  input  logic [DATA_WIDTH-1:0]            data,
  input  logic [ID_WIDTH-1:0]              id,
  input  logic                             enable,
  output logic                             full,
  output logic                             overflow,
  output logic [$clog2(DEPTH):0]           count,
  output logic [2*ID_WIDTH+DATA_WIDTH-1:0] tx_out,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic                             busy,
  output logic                             drop
);

  localparam int unsigned PKT_W = 2 * ID_WIDTH + DATA_WIDTH;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
    $error("tx_packet_queue: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 2");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state;
  state_t             next_state;
  logic [PKT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               load;
  logic               clr;
  logic               timeout;
  logic               tx_valid_next;
  logic [CNT_W-1:0]   count_next;
  logic               full_next;

  // Next state: a load always pops the FIFO head into the output register.
  always_comb begin
    next_state    = state;
    load          = 1'b0;
    clr           = 1'b0;
    push          = enable && !full;
    case (state)
      IDLE: begin
        if (count != '0) begin
          load       = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        if (tx_ready || timeout) begin
          if (count != '0) begin
            load = 1'b1;
          end else begin
            clr        = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
    tx_valid_next = load || (tx_valid && !clr);
    count_next    = count + CNT_W'(push) - CNT_W'(load);
    full_next     = (count_next == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Storage array carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {dest_id, data, id};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      tx_valid <= 1'b0;
      tx_out   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (load) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        tx_out <= mem[rd_ptr];
      end else if (clr) begin
        tx_out <= '0;
      end
      count    <= count_next;
      full     <= full_next;
      overflow <= overflow || (enable && full);
      busy     <= tx_valid_next || (count_next != '0);
      tx_valid <= tx_valid_next;
    end
  end

`ifdef TX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT);

  logic [TW-1:0] wait_cnt;

  assign timeout = (state == SEND) && !tx_ready && (wait_cnt == TW'(TIMEOUT - 1));

  // Grant-wait counter restarts with every packet presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      drop     <= 1'b0;
    end else begin
      if (load || clr) begin
        wait_cnt <= '0;
      end else if (state == SEND && !tx_ready) begin
        wait_cnt <= wait_cnt + TW'(1);
      end
      drop <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign drop    = 1'b0;
`endif

endmodule
